// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//
// Purpose:
//   Two-requester arbiter sharing a single uart_tx byte channel. Requester 0 is
//   the ram_rw debug/readback path and requester 1 is the CPU console path.
//   A grant is held for a whole packet (up to and including the beat flagged
//   last), so multi-byte messages never interleave. Ties in IDLE go
//   round-robin. A one-deep output register feeds uart_tx and supports a
//   simultaneous drain and load, so bytes flow back-to-back without bubbles.
//   A lock whose owner goes quiet for LOCK_TIMEOUT cycles is released.
//
// Parameters:
//   LOCK_TIMEOUT  owner-idle cycles tolerated while locked (0 = never release)
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   reqN_data_i    requester N byte
//   reqN_vld_i     requester N byte valid
//   reqN_last_i    requester N last byte of packet (qualified by vld)
//   reqN_rdy_o     requester N byte accepted this cycle when vld is high
//   tx_data_o      byte to uart_tx
//   tx_data_vld_o  tx_data_o valid
//   tx_data_rdy_i  uart_tx ready; a byte moves when vld && rdy
//   grant_o        one-hot current owner, 00 when idle
//   busy_o         owner locked or output register full
//
// Optional feature (define UART_TX_ARB_STAT_EN):
//   stat0_cnt_o    saturating count of bytes accepted from port 0
//   stat1_cnt_o    saturating count of bytes accepted from port 1
//   stat_timeout_o saturating count of forced timeout releases
// -----------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  req0_data_i,
  input  logic        req0_vld_i,
  input  logic        req0_last_i,
  output logic        req0_rdy_o,
  input  logic [7:0]  req1_data_i,
  input  logic        req1_vld_i,
  input  logic        req1_last_i,
  output logic        req1_rdy_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_data_vld_o,
  input  logic        tx_data_rdy_i,
  output logic [1:0]  grant_o,
  output logic        busy_o
`ifdef UART_TX_ARB_STAT_EN
  ,
  output logic [15:0] stat0_cnt_o,
  output logic [15:0] stat1_cnt_o,
  output logic [7:0]  stat_timeout_o
`endif
);

  localparam int unsigned     CNT_W      = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LOCK_TIMEOUT);
  localparam bit              TIMEOUT_EN = (LOCK_TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;  // port granted most recently
  logic [CNT_W-1:0] to_cnt_q;
  logic             out_vld_q;
  logic [7:0]       out_data_q;

  logic             out_free;
  logic             own_vld;
  logic             own_last;
  logic [7:0]       own_data;
  logic             accept0, accept1, accept;
  logic             timeout_hit;

  // The output register can take a new byte when empty or when its current
  // byte leaves this very cycle (drain and load together).
  assign out_free   = !out_vld_q || tx_data_rdy_i;
  assign req0_rdy_o = (state_q == LOCK0) && out_free;
  assign req1_rdy_o = (state_q == LOCK1) && out_free;
  assign accept0    = req0_vld_i && req0_rdy_o;
  assign accept1    = req1_vld_i && req1_rdy_o;
  assign accept     = accept0 || accept1;

  // Signals of whichever port currently owns the lock.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_data = req0_data_i;
    case (state_q)
      LOCK0: begin
        own_vld  = req0_vld_i;
        own_last = req0_last_i;
        own_data = req0_data_i;
      end
      LOCK1: begin
        own_vld  = req1_vld_i;
        own_last = req1_last_i;
        own_data = req1_data_i;
      end
      default: ;
    endcase
  end

  assign timeout_hit = TIMEOUT_EN && (state_q != IDLE) && (to_cnt_q == CNT_MAX);

  // Next-state logic. An accepted beat takes priority over a timeout: a
  // returning owner keeps its lock.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req0_vld_i && req1_vld_i) begin
          state_d = last_grant_q ? LOCK0 : LOCK1;
        end else if (req0_vld_i) begin
          state_d = LOCK0;
        end else if (req1_vld_i) begin
          state_d = LOCK1;
        end
      end
      LOCK0, LOCK1: begin
        if ((accept && own_last) || (!accept && timeout_hit)) begin
          state_d      = IDLE;
          last_grant_d = (state_q == LOCK1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Owner-idle counter: held at zero in IDLE so it starts clean on entering a
  // lock, cleared by any accepted beat, and saturating so it never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if (state_q == IDLE || accept) begin
      to_cnt_q <= '0;
    end else if (TIMEOUT_EN && !own_vld && to_cnt_q != CNT_MAX) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end

  // Output register toward uart_tx.
  // NOTE: the data byte is reset along with vld because its reset value is
  // visible on tx_data_o; pure storage that is never observed before being
  // written would not need a reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q  <= 1'b0;
      out_data_q <= 8'h00;
    end else if (accept) begin
      out_vld_q  <= 1'b1;
      out_data_q <= own_data;
    end else if (tx_data_rdy_i) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign tx_data_o     = out_data_q;
  assign tx_data_vld_o = out_vld_q;
  assign grant_o       = {state_q == LOCK1, state_q == LOCK0};
  assign busy_o        = (state_q != IDLE) || out_vld_q;

`ifdef UART_TX_ARB_STAT_EN
  logic timeout_rel;
  assign timeout_rel = !accept && timeout_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat0_cnt_o    <= 16'h0000;
      stat1_cnt_o    <= 16'h0000;
      stat_timeout_o <= 8'h00;
    end else begin
      if (accept0 && stat0_cnt_o != 16'hffff) stat0_cnt_o <= stat0_cnt_o + 16'd1;
      if (accept1 && stat1_cnt_o != 16'hffff) stat1_cnt_o <= stat1_cnt_o + 16'd1;
      if (timeout_rel && stat_timeout_o != 8'hff) stat_timeout_o <= stat_timeout_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Self-checking bench for uart_tx_arb (LOCK_TIMEOUT = 4). A behavioural model
// tracks owner, round-robin pointer, the one-byte output slot and the idle
// counter as plain integers and is compared with the DUT every cycle; a
// scoreboard queue checks that every accepted byte leaves exactly once and in
// order. Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int LT = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] req0_data_i = 8'h00;
  logic       req0_vld_i  = 1'b0;
  logic       req0_last_i = 1'b0;
  logic       req0_rdy_o;
  logic [7:0] req1_data_i = 8'h00;
  logic       req1_vld_i  = 1'b0;
  logic       req1_last_i = 1'b0;
  logic       req1_rdy_o;
  logic [7:0] tx_data_o;
  logic       tx_data_vld_o;
  logic       tx_data_rdy_i = 1'b1;
  logic [1:0] grant_o;
  logic       busy_o;
`ifdef UART_TX_ARB_STAT_EN
  logic [15:0] stat0_cnt_o;
  logic [15:0] stat1_cnt_o;
  logic [7:0]  stat_timeout_o;
`endif

  uart_tx_arb #(.LOCK_TIMEOUT(LT)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req0_data_i   (req0_data_i),
    .req0_vld_i    (req0_vld_i),
    .req0_last_i   (req0_last_i),
    .req0_rdy_o    (req0_rdy_o),
    .req1_data_i   (req1_data_i),
    .req1_vld_i    (req1_vld_i),
    .req1_last_i   (req1_last_i),
    .req1_rdy_o    (req1_rdy_o),
    .tx_data_o     (tx_data_o),
    .tx_data_vld_o (tx_data_vld_o),
    .tx_data_rdy_i (tx_data_rdy_i),
    .grant_o       (grant_o),
    .busy_o        (busy_o)
`ifdef UART_TX_ARB_STAT_EN
    ,
    .stat0_cnt_o   (stat0_cnt_o),
    .stat1_cnt_o   (stat1_cnt_o),
    .stat_timeout_o(stat_timeout_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------- bookkeeping
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  typedef struct {
    logic [7:0] data;
    logic       last;
    bit         idle;   // one cycle with vld low instead of a byte
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t b0, b1;
  bit    fired [2];     // byte accepted at the coming edge (from the model)
  int    rdy_mode = 0;  // 0: always ready, 1: 1 high / 3 low, 2: random, 3: stalled
  int    phase = 0;

  task automatic push(input int port, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l; b.idle = 1'b0;
    if (port == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic gap(input int port, input int n);
    beat_t b;
    b.data = 8'h00; b.last = 1'b0; b.idle = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (port == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // Requesters hold vld/data until the byte is accepted, then take the next
  // queued beat in the same cycle.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (req0_vld_i && fired[0]) req0_vld_i = 1'b0;
      if (!req0_vld_i && q0.size() > 0) begin
        b0 = q0.pop_front();
        if (!b0.idle) begin
          req0_vld_i = 1'b1; req0_data_i = b0.data; req0_last_i = b0.last;
        end
      end
      if (req1_vld_i && fired[1]) req1_vld_i = 1'b0;
      if (!req1_vld_i && q1.size() > 0) begin
        b1 = q1.pop_front();
        if (!b1.idle) begin
          req1_vld_i = 1'b1; req1_data_i = b1.data; req1_last_i = b1.last;
        end
      end
      case (rdy_mode)
        0:       tx_data_rdy_i = 1'b1;
        1:       tx_data_rdy_i = ((phase % 4) == 0);
        2:       tx_data_rdy_i = 1'($urandom_range(0, 1));
        default: tx_data_rdy_i = 1'b0;
      endcase
      phase++;
    end
  end

  // ---------------------------------------------------------------- reference model
  int         m_owner = -1;  // -1 idle, else owning port
  int         m_last  = 1;
  bit         m_ovld  = 1'b0;
  logic [7:0] m_odata = 8'h00;
  int         m_cnt   = 0;
  int         m_s0 = 0, m_s1 = 0, m_sto = 0;
  logic [7:0] sb[$];         // accepted, not yet transmitted
  logic [7:0] xlog[$];       // transmitted bytes, in order

  always @(negedge clk_i) begin
    bit         e_rdy0, e_rdy1, acc0, acc1, ov, ol;
    logic [7:0] acc_data;
    e_rdy0 = (m_owner == 0) && (!m_ovld || tx_data_rdy_i);
    e_rdy1 = (m_owner == 1) && (!m_ovld || tx_data_rdy_i);
    if (chk_en) begin
      check("grant", grant_o, (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10));
      check("tx_vld", tx_data_vld_o, m_ovld);
      check("tx_data", tx_data_o, m_odata);
      check("busy", busy_o, (m_owner >= 0) || m_ovld);
      check("rdy0", req0_rdy_o, e_rdy0);
      check("rdy1", req1_rdy_o, e_rdy1);
`ifdef UART_TX_ARB_STAT_EN
      check("stat0", stat0_cnt_o, m_s0);
      check("stat1", stat1_cnt_o, m_s1);
      check("stat_to", stat_timeout_o, m_sto);
`endif
    end
    if (rst_i) begin
      m_owner = -1; m_last = 1; m_ovld = 1'b0; m_odata = 8'h00; m_cnt = 0;
      m_s0 = 0; m_s1 = 0; m_sto = 0;
      sb.delete();
      fired[0] = 1'b0; fired[1] = 1'b0;
    end else begin
      acc0 = req0_vld_i && e_rdy0;
      acc1 = req1_vld_i && e_rdy1;
      fired[0] = acc0; fired[1] = acc1;
      acc_data = acc0 ? req0_data_i : req1_data_i;
      // Transfer leaving the slot this edge.
      if (m_ovld && tx_data_rdy_i) begin
        xlog.push_back(tx_data_o);
        if (chk_en) check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) check("xfer_order", tx_data_o, sb.pop_front());
      end
      if (acc0 || acc1) begin
        sb.push_back(acc_data);
        m_ovld = 1'b1; m_odata = acc_data;
      end else if (m_ovld && tx_data_rdy_i) begin
        m_ovld = 1'b0;
      end
      if (acc0 && m_s0 < 65535) m_s0++;
      if (acc1 && m_s1 < 65535) m_s1++;
      // Ownership.
      if (m_owner < 0) begin
        if (req0_vld_i && req1_vld_i) m_owner = (m_last == 1) ? 0 : 1;
        else if (req0_vld_i)          m_owner = 0;
        else if (req1_vld_i)          m_owner = 1;
        m_cnt = 0;
      end else begin
        ov = (m_owner == 0) ? req0_vld_i  : req1_vld_i;
        ol = (m_owner == 0) ? req0_last_i : req1_last_i;
        if (acc0 || acc1) begin
          m_cnt = 0;
          if (ol) begin m_last = m_owner; m_owner = -1; end
        end else if (m_cnt == LT) begin
          m_last = m_owner; m_owner = -1; m_cnt = 0;
          if (m_sto < 255) m_sto++;
        end else if (!ov) begin
          m_cnt++;
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic do_reset();
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (k < budget && !(q0.size() == 0 && q1.size() == 0 && !req0_vld_i &&
                           !req1_vld_i && m_owner < 0 && !m_ovld)) begin
      @(negedge clk_i);
      k++;
    end
    check("drain_done", k < budget, 1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic check_log(input string nm, input logic [7:0] exp_q[$]);
    check({nm, "_len"}, xlog.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < xlog.size()) check(nm, xlog[i], exp_q[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scenarios
  initial begin
    logic [7:0] e[$];
    int total;

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk_en = 1'b1;
    @(negedge clk_i);
    check("rst_grant", grant_o, 2'b00);
    check("rst_vld", tx_data_vld_o, 1'b0);
    check("rst_data", tx_data_o, 8'h00);

    // 1) Single requester, 3-byte packet, uart always ready.
    xlog.delete();
    @(posedge clk_i); #1;
    push(0, 8'h2a, 1'b0); push(0, 8'h2b, 1'b0); push(0, 8'h2c, 1'b1);
    @(negedge clk_i); check("t1_grant_t0", grant_o, 2'b00);
    @(negedge clk_i); check("t1_grant_t1", grant_o, 2'b01);
                      check("t1_rdy0_t1", req0_rdy_o, 1'b1);
    @(negedge clk_i); check("t1_vld_t2", tx_data_vld_o, 1'b1);
                      check("t1_data_t2", tx_data_o, 8'h2a);
    @(negedge clk_i); check("t1_data_t3", tx_data_o, 8'h2b);
                      check("t1_grant_t3", grant_o, 2'b01);
    @(negedge clk_i); check("t1_data_t4", tx_data_o, 8'h2c);
                      check("t1_grant_t4", grant_o, 2'b00);
    @(negedge clk_i); check("t1_vld_t5", tx_data_vld_o, 1'b0);
    wait_drain(50);
    e = '{8'h2a, 8'h2b, 8'h2c};
    check_log("t1_log", e);

    // 2) Tie after reset goes to port 0; port 0 re-requesting at once then
    //    loses the next tie to port 1.
    do_reset();
    xlog.delete();
    @(posedge clk_i); #1;
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1); push(0, 8'h30, 1'b0); push(0, 8'h31, 1'b1);
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i); check("t2_tie_grant", grant_o, 2'b01);
    wait_drain(100);
    e = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};
    check_log("t2_log", e);

    // 3) Back-pressure: uart ready 1 cycle in 4.
    do_reset();
    xlog.delete();
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) push(0, 8'(8'h40 + i), i == 5);
    wait_drain(200);
    e = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    check_log("t3_log", e);
    rdy_mode = 0;

    // 4) Lock timeout: port 1 sends one byte without last and goes quiet.
    do_reset();
    xlog.delete();
    @(posedge clk_i); #1 push(1, 8'h55, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i); check("t4_grant_t1", grant_o, 2'b10);
    @(posedge clk_i); #1 push(0, 8'h66, 1'b1);
    repeat (4) @(negedge clk_i);
    @(negedge clk_i); check("t4_grant_t6", grant_o, 2'b10);
                      check("t4_rdy0_t6", req0_rdy_o, 1'b0);
    @(negedge clk_i); check("t4_grant_t7", grant_o, 2'b00);
    @(negedge clk_i); check("t4_grant_t8", grant_o, 2'b01);
    wait_drain(50);
`ifdef UART_TX_ARB_STAT_EN
    check("t4_stat_to", stat_timeout_o, 8'd1);
`endif
    e = '{8'h55, 8'h66};
    check_log("t4_log", e);

    // 5) Reset while the output register holds 8'h93.
    do_reset();
    xlog.delete();
    rdy_mode = 3;
    @(posedge clk_i); #1 push(0, 8'h93, 1'b1);
    for (int k = 0; k < 10 && !m_ovld; k++) @(negedge clk_i);
    @(negedge clk_i);
    check("t5_pre_vld", tx_data_vld_o, 1'b1);
    check("t5_pre_data", tx_data_o, 8'h93);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("t5_vld", tx_data_vld_o, 1'b0);
    check("t5_data", tx_data_o, 8'h00);
    check("t5_grant", grant_o, 2'b00);
    check("t5_busy", busy_o, 1'b0);
    check("t5_rdy", {req1_rdy_o, req0_rdy_o}, 2'b00);
    rdy_mode = 0;
    repeat (5) @(negedge clk_i);
    check("t5_no_xfer", xlog.size(), 0);

    // 6) Byte statistics: 5 bytes from port 0, 2 from port 1.
    do_reset();
    xlog.delete();
    @(posedge clk_i); #1;
    for (int i = 0; i < 5; i++) push(0, 8'(8'h70 + i), i == 4);
    push(1, 8'h80, 1'b0); push(1, 8'h81, 1'b1);
    wait_drain(100);
    e = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h80, 8'h81};
    check_log("t6_log", e);
`ifdef UART_TX_ARB_STAT_EN
    check("t6_stat0", stat0_cnt_o, 16'd5);
    check("t6_stat1", stat1_cnt_o, 16'd2);
    check("t6_stat_to", stat_timeout_o, 8'd0);
`endif

    // 7) Randomized traffic on both ports with random uart readiness and
    //    occasional mid-packet gaps long enough to hit the lock timeout.
    do_reset();
    xlog.delete();
    rdy_mode = 2;
    total = 0;
    for (int p = 0; p < 60; p++) begin
      int port;
      int len;
      port = $urandom_range(0, 1);
      len  = $urandom_range(1, 4);
      gap(port, $urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 7) == 0) gap(port, $urandom_range(1, 7));
        push(port, 8'($urandom), i == len - 1);
        total++;
      end
    end
    wait_drain(5000);
    check("t7_count", xlog.size(), total);
    check("t7_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
